// File: rtl/uarts_rx_bittiming_pkg.sv
// Shared state encodings, control-bit indices and helpers for the UART slave receive bit-timing front end.
package uarts_rx_bittiming_pkg;

   typedef enum logic [2:0] {
      BT_IDLE,
      BT_START,
      BT_DATA,
      BT_PARITY,
      BT_STOP,
      BT_BREAK
   } bt_state_e;

   localparam int unsigned CTL_PAR_EN   = 2;
   localparam int unsigned CTL_PAR_EVEN = 3;
   localparam int unsigned BAUD_MIN     = 4;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uarts_rx_bittiming_sync.sv
// RX line synchroniser: SYNC_STAGES flops, all resetting to the idle-high line level.
module uarts_sync
   import uarts_rx_bittiming_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic hclk,
   input  logic hresetn,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) ff <= '1;
      else          ff <= {ff[SYNC_STAGES-2:0], d};
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uarts_rx_bittiming.sv
// UART slave receive bit timing: start qualification, mid-bit sampling, parity/framing checks.
// Optional UARTS_RX_MAJORITY_EN: 2-of-3 majority sampling around each mid-point.
module uarts_rx_bittiming
   import uarts_rx_bittiming_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned BAUD_W      = 16
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic [31:0] uarts_baud,
   input  logic [31:0] uarts_ctl,
   input  logic [7:0]  uarts_dw,
   input  logic [7:0]  uarts_plw,
   input  logic        RX,
   output logic        rx_bit,
   output logic        sample_data_bit,
   output logic [7:0]  bit_cnt,
   output logic        parity_err,
   output logic        frame_err,
   output logic        rx_busy
);

   bt_state_e         state, state_n;
   logic [BAUD_W-1:0] cnt, cnt_n;
   logic [BAUD_W-1:0] baud_lat, baud_lat_n;
   logic [BAUD_W-1:0] baud_eff;
   logic              rx_d1;
   logic              xor_acc, xor_n;
   logic              sdb_n, perr_n, ferr_n;
   logic [7:0]        bit_cnt_n;
   logic              sample_now, sample_val;
   logic              unused_bits;

   assign unused_bits = ^{uarts_baud[31:BAUD_W], uarts_ctl[31:4], uarts_ctl[1:0]};

   uarts_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .hclk    (hclk),
      .hresetn (hresetn),
      .d       (RX),
      .q       (rx_bit)
   );

   // Illegal divisors below the minimum are clamped so the half-bit load never underflows.
   assign baud_eff = (uarts_baud[BAUD_W-1:0] < BAUD_W'(BAUD_MIN)) ? BAUD_W'(BAUD_MIN)
                                                                  : uarts_baud[BAUD_W-1:0];

`ifdef UARTS_RX_MAJORITY_EN
   // Vote is taken the cycle after the counter hits 0, using rx_bit at counts 1, 0 and now.
   logic rx_d2, pend;
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         rx_d2 <= 1'b1;
         pend  <= 1'b0;
      end else begin
         rx_d2 <= rx_d1;
         pend  <= (state inside {BT_START, BT_DATA, BT_PARITY, BT_STOP}) && (cnt == '0);
      end
   end
   assign sample_now = pend;
   assign sample_val = maj3(rx_d2, rx_d1, rx_bit);
`else
   assign sample_now = (cnt == '0);
   assign sample_val = rx_bit;
`endif

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state           <= BT_IDLE;
         cnt             <= '0;
         baud_lat        <= BAUD_W'(BAUD_MIN);
         rx_d1           <= 1'b1;
         xor_acc         <= 1'b0;
         sample_data_bit <= 1'b0;
         bit_cnt         <= '0;
         parity_err      <= 1'b0;
         frame_err       <= 1'b0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         baud_lat        <= baud_lat_n;
         rx_d1           <= rx_bit;
         xor_acc         <= xor_n;
         sample_data_bit <= sdb_n;
         bit_cnt         <= bit_cnt_n;
         parity_err      <= perr_n;
         frame_err       <= ferr_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      baud_lat_n = baud_lat;
      xor_n      = xor_acc;
      sdb_n      = 1'b0;
      bit_cnt_n  = bit_cnt;
      perr_n     = 1'b0;
      ferr_n     = 1'b0;

      if (state != BT_IDLE && state != BT_BREAK)
         cnt_n = (cnt == '0) ? baud_lat - BAUD_W'(1) : cnt - BAUD_W'(1);

      case (state)
         BT_IDLE: begin
            bit_cnt_n = '0;
            if (rx_d1 && !rx_bit) begin
               cnt_n      = (baud_eff >> 1) - BAUD_W'(1);
               baud_lat_n = baud_eff;
               xor_n      = 1'b0;
               state_n    = BT_START;
            end
         end
         BT_START: begin
            if (sample_now) state_n = sample_val ? BT_IDLE : BT_DATA;
         end
         BT_DATA: begin
            if (sample_now) begin
               sdb_n     = 1'b1;
               bit_cnt_n = bit_cnt + 8'd1;
               xor_n     = xor_acc ^ sample_val;
               if (bit_cnt + 8'd1 == uarts_dw)
                  state_n = uarts_ctl[CTL_PAR_EN] ? BT_PARITY : BT_STOP;
            end
         end
         BT_PARITY: begin
            if (sample_now) begin
               sdb_n     = 1'b1;
               bit_cnt_n = uarts_dw + 8'd1;
               perr_n    = xor_acc ^ sample_val ^ ~uarts_ctl[CTL_PAR_EVEN];
               state_n   = BT_STOP;
            end
         end
         BT_STOP: begin
            if (sample_now) begin
               sdb_n     = 1'b1;
               bit_cnt_n = uarts_plw;
               ferr_n    = ~sample_val;
               state_n   = sample_val ? BT_IDLE : BT_BREAK;
            end
         end
         BT_BREAK: begin
            bit_cnt_n = '0;
            if (rx_bit) state_n = BT_IDLE;
         end
         default: state_n = BT_IDLE;
      endcase
   end

   assign rx_busy = (state != BT_IDLE);

endmodule

// File: tb/tb_uarts_rx_bittiming.sv
// Self-checking bench for uarts_rx_bittiming: frame-level timing model plus literal pins.
`timescale 1ns/1ps
module tb_uarts_rx_bittiming;

   localparam int SYNC = 2;
`ifdef UARTS_RX_MAJORITY_EN
   localparam int LAT_ADJ = 1;
   localparam bit MAJ     = 1'b1;
`else
   localparam int LAT_ADJ = 0;
   localparam bit MAJ     = 1'b0;
`endif

   typedef struct {
      longint at;
      int     idx;
      bit     perr;
      bit     ferr;
   } ev_t;

   logic        hclk = 1'b0;
   logic        hresetn = 1'b0;
   logic [31:0] uarts_baud = 32'd16;
   logic [31:0] uarts_ctl = 32'd0;
   logic [7:0]  uarts_dw = 8'd8;
   logic [7:0]  uarts_plw = 8'd9;
   logic        RX = 1'b1;
   logic        rx_bit, sample_data_bit, parity_err, frame_err, rx_busy;
   logic [7:0]  bit_cnt;

   int     errors = 0;
   int     checks = 0;
   longint cyc = 0;
   bit     chk_en = 1'b0;
   int     exp_bitcnt = 0;
   int     cur_plw = 9;
   longint pulse_at [64];
   ev_t    exp_q [$];

   uarts_rx_bittiming #(.SYNC_STAGES(2), .BAUD_W(16)) dut (
      .hclk            (hclk),
      .hresetn         (hresetn),
      .uarts_baud      (uarts_baud),
      .uarts_ctl       (uarts_ctl),
      .uarts_dw        (uarts_dw),
      .uarts_plw       (uarts_plw),
      .RX              (RX),
      .rx_bit          (rx_bit),
      .sample_data_bit (sample_data_bit),
      .bit_cnt         (bit_cnt),
      .parity_err      (parity_err),
      .frame_err       (frame_err),
      .rx_busy         (rx_busy)
   );

   always #5 hclk = ~hclk;
   always @(posedge hclk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Per-cycle compare against the expected pulse schedule.
   initial begin
      ev_t ev;
      forever begin
         @(posedge hclk);
         #1;
         if (chk_en) begin
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
               ev = exp_q.pop_front();
               check("pulse", sample_data_bit, 1);
               check("pulse_bit_cnt", bit_cnt, ev.idx);
               check("pulse_parity_err", parity_err, ev.perr);
               check("pulse_frame_err", frame_err, ev.ferr);
               exp_bitcnt = (ev.idx == cur_plw) ? 0 : ev.idx;
            end else begin
               check("no_pulse", sample_data_bit, 0);
               check("no_parity_err", parity_err, 0);
               check("no_frame_err", frame_err, 0);
               check("bit_cnt_hold", bit_cnt, exp_bitcnt);
            end
            if (sample_data_bit === 1'b1 && bit_cnt < 8'd64) pulse_at[bit_cnt] = cyc;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic clear_pulses();
      for (int i = 0; i < 64; i++) pulse_at[i] = -1;
   endtask

   task automatic idle(input int n);
      RX = 1'b1;
      repeat (n) @(negedge hclk);
   endtask

   // Drives one frame (start, dw data LSB-first, optional parity, stop) and queues expected pulses.
   task automatic send_frame(input int n, input logic [31:0] data, input int dw,
                             input bit par_en, input bit even, input bit par_bit,
                             input bit stop_bit, input int tail_low, input int glitch_k,
                             input int limit, input bit poke_baud, output longint c0);
      int plw;
      int total;
      bit slot [0:40];
      bit tot;
      bit rd;
      bit v;
      ev_t ev;
      plw   = dw + int'(par_en) + 1;
      total = (1 + plw) * n;
      slot[0] = 1'b0;
      for (int k = 1; k <= dw; k++) slot[k] = data[k-1];
      if (par_en) slot[dw+1] = par_bit;
      slot[plw] = stop_bit;
      uarts_baud = 32'(n);
      uarts_ctl  = {28'd0, even, par_en, 2'b00};
      uarts_dw   = 8'(dw);
      uarts_plw  = 8'(plw);
      cur_plw    = plw;
      @(negedge hclk);
      c0  = cyc + 1;
      tot = 1'b0;
      for (int k = 1; k <= plw; k++) begin
         rd = slot[k];
         if (k == glitch_k && !MAJ) rd = 1'b1;
         ev.at   = c0 + SYNC + n / 2 + k * n + LAT_ADJ;
         ev.idx  = k;
         ev.perr = par_en && (k == dw + 1) && ((tot ^ rd) ^ !even);
         ev.ferr = (k == plw) && !rd;
         if (k <= dw) tot ^= rd;
         exp_q.push_back(ev);
      end
      for (int i = 0; i < total; i++) begin
         if (limit > 0 && i >= limit) break;
         v = slot[i / n];
         if (glitch_k > 0 && i == glitch_k * n + n / 2) v = 1'b1;
         RX = v;
         if (poke_baud && i == 3 * n) uarts_baud = 32'd5;
         @(negedge hclk);
      end
      if (limit == 0 && !stop_bit) begin
         repeat (tail_low) begin
            RX = 1'b0;
            @(negedge hclk);
         end
      end
      RX = 1'b1;
      uarts_baud = 32'(n);
   endtask

   initial begin
      longint c0;
      clear_pulses();
      repeat (3) @(negedge hclk);
      check("reset_rx_bit", rx_bit, 1);
      check("reset_sample", sample_data_bit, 0);
      check("reset_bit_cnt", bit_cnt, 0);
      check("reset_parity_err", parity_err, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_busy", rx_busy, 0);
      hresetn = 1'b1;
      repeat (4) @(negedge hclk);
      exp_bitcnt = 0;
      chk_en = 1'b1;

      // 0xA5, 8N1, N=16
      clear_pulses();
      send_frame(16, 32'hA5, 8, 0, 0, 0, 1, 0, 0, 0, 0, c0);
      idle(40);
      check("t_first_sample", pulse_at[1] - c0, 26 + LAT_ADJ);
      check("t_spacing", pulse_at[2] - pulse_at[1], 16);
      check("t_stop_sample", pulse_at[9] - c0, 154 + LAT_ADJ);
      check("busy_after_frame", rx_busy, 0);

      // Even parity: 0x07 + parity 1 is good (baud poked mid-frame), parity 0 is bad
      send_frame(16, 32'h07, 8, 1, 1, 1, 1, 0, 0, 0, 1, c0);
      idle(40);
      clear_pulses();
      send_frame(16, 32'h07, 8, 1, 1, 0, 1, 0, 0, 0, 0, c0);
      idle(40);
      check("t_parity_sample", pulse_at[9] - c0, 154 + LAT_ADJ);
      // Odd parity: 0x07 + parity 0 is good
      send_frame(16, 32'h07, 8, 1, 0, 0, 1, 0, 0, 0, 0, c0);
      idle(40);

      // False start: 4 low cycles
      uarts_baud = 32'd16;
      @(negedge hclk);
      c0 = cyc + 1;
      repeat (4) begin
         RX = 1'b0;
         @(negedge hclk);
      end
      RX = 1'b1;
      check("false_start_busy", rx_busy, 1);
      while (cyc < c0 + 9 + LAT_ADJ) @(negedge hclk);
      check("false_start_busy_end", rx_busy, 1);
      @(negedge hclk);
      check("false_start_idle", rx_busy, 0);
      idle(20);

      // Stop bit 0 followed by 40 low cycles -> break
      send_frame(16, 32'h00, 8, 0, 0, 0, 0, 40, 0, 0, 0, c0);
      check("break_busy", rx_busy, 1);
      check("break_bit_cnt", bit_cnt, 0);
      idle(8);
      check("break_exit", rx_busy, 0);
      clear_pulses();
      send_frame(16, 32'h3C, 8, 0, 0, 0, 1, 0, 0, 0, 0, c0);
      idle(40);
      check("t_after_break", pulse_at[1] - c0, 26 + LAT_ADJ);

      // Reset while bit_cnt = 4
      send_frame(16, 32'hA5, 8, 0, 0, 0, 1, 0, 0, 76 + LAT_ADJ, 0, c0);
      check("abort_bit_cnt", bit_cnt, 4);
      check("abort_busy", rx_busy, 1);
      chk_en = 1'b0;
      exp_q.delete();
      hresetn = 1'b0;
      #1;
      check("abort_rx_bit", rx_bit, 1);
      check("abort_sample", sample_data_bit, 0);
      check("abort_bit_cnt_rst", bit_cnt, 0);
      check("abort_parity_err", parity_err, 0);
      check("abort_frame_err", frame_err, 0);
      check("abort_busy_rst", rx_busy, 0);
      repeat (3) @(negedge hclk);
      hresetn = 1'b1;
      repeat (3) @(negedge hclk);
      exp_bitcnt = 0;
      chk_en = 1'b1;
      clear_pulses();
      send_frame(16, 32'h5A, 8, 0, 0, 0, 1, 0, 0, 0, 0, c0);
      idle(40);
      check("t_after_reset", pulse_at[9] - c0, 154 + LAT_ADJ);

      // Minimum divisor, single data bit
      clear_pulses();
      send_frame(4, 32'h1, 1, 0, 0, 0, 1, 0, 0, 0, 0, c0);
      idle(16);
      check("t_n4_data", pulse_at[1] - c0, 8 + LAT_ADJ);
      check("t_n4_stop", pulse_at[2] - c0, 12 + LAT_ADJ);

      // One-cycle high glitch at the mid-point of data bit 3 (a 0), even parity
      send_frame(16, 32'h00, 8, 1, 1, 0, 1, 0, 3, 0, 0, c0);
      idle(40);

      check("pending_pulses", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
